// File: rtl/hazard_unit.sv
// RAW hazard detection for a 5-stage pipe: shadows EX/MEM destinations, stalls IF/ID, bubbles EX.
// Stall/bubble are combinational from ID; forwarding selects are registered and line up with EX.
module hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter bit FWD_EN     = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_rs1_re,
  input  logic                  i_id_rs2_re,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_rd_we,
  input  logic                  i_id_mem_re,
  input  logic                  i_flush,
  input  logic                  i_mem_stall,
  output logic                  o_stall_if,
  output logic                  o_stall_id,
  output logic                  o_bubble_ex,
  output logic [1:0]            o_fwd_a,
  output logic [1:0]            o_fwd_b,
  output logic [CNT_W-1:0]      o_stall_cnt
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b01;
  localparam logic [1:0] FWD_MWB = 2'b10;

  // The WB slot is not tracked: the regfile is write-first, so a WB producer never hazards.
  logic [REG_ADDR_W-1:0] r_ex_rd;
  logic                  r_ex_we;
  logic                  r_ex_ld;
  logic [REG_ADDR_W-1:0] r_mem_rd;
  logic                  r_mem_we;
  logic [1:0]            r_fwd_a;
  logic [1:0]            r_fwd_b;
  logic [CNT_W-1:0]      r_stall_cnt;

  logic       w_rs1_ex;
  logic       w_rs2_ex;
  logic       w_rs1_mem;
  logic       w_rs2_mem;
  logic       w_raw_stall;
  logic       w_ex_kill;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  assign w_rs1_ex  = i_id_rs1_re & i_id_valid & r_ex_we  & (r_ex_rd  == i_id_rs1) & (i_id_rs1 != '0);
  assign w_rs2_ex  = i_id_rs2_re & i_id_valid & r_ex_we  & (r_ex_rd  == i_id_rs2) & (i_id_rs2 != '0);
  assign w_rs1_mem = i_id_rs1_re & i_id_valid & r_mem_we & (r_mem_rd == i_id_rs1) & (i_id_rs1 != '0);
  assign w_rs2_mem = i_id_rs2_re & i_id_valid & r_mem_we & (r_mem_rd == i_id_rs2) & (i_id_rs2 != '0);

  always_comb begin
    w_raw_stall = 1'b0;
    if (FWD_EN) begin
      w_raw_stall = (w_rs1_ex | w_rs2_ex) & r_ex_ld;
    end else begin
      w_raw_stall = w_rs1_ex | w_rs2_ex | w_rs1_mem | w_rs2_mem;
    end
  end

  // Youngest producer wins: an EX/MEM ALU result beats the older MEM/WB value.
  function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem, input logic ex_ld);
    logic [1:0] sel;
    sel = FWD_RF;
    if (FWD_EN) begin
      if (hit_ex && !ex_ld) begin
        sel = FWD_EXM;
      end else if (hit_mem) begin
        sel = FWD_MWB;
      end
    end
    return sel;
  endfunction

  assign w_fwd_a   = fwd_sel(w_rs1_ex, w_rs1_mem, r_ex_ld);
  assign w_fwd_b   = fwd_sel(w_rs2_ex, w_rs2_mem, r_ex_ld);
  assign w_ex_kill = i_flush | w_raw_stall;

  always_comb begin
    o_stall_if  = 1'b0;
    o_stall_id  = 1'b0;
    o_bubble_ex = 1'b0;
    if (i_mem_stall) begin
      o_stall_if = 1'b1;
      o_stall_id = 1'b1;
    end else if (i_flush) begin
      o_bubble_ex = 1'b1;
    end else if (w_raw_stall) begin
      o_stall_if  = 1'b1;
      o_stall_id  = 1'b1;
      o_bubble_ex = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex_rd     <= '0;
      r_ex_we     <= 1'b0;
      r_ex_ld     <= 1'b0;
      r_mem_rd    <= '0;
      r_mem_we    <= 1'b0;
      r_fwd_a     <= FWD_RF;
      r_fwd_b     <= FWD_RF;
      r_stall_cnt <= '0;
    end else if (!i_mem_stall) begin
      r_mem_rd <= r_ex_rd;
      r_mem_we <= r_ex_we;
      if (w_ex_kill) begin
        r_ex_rd <= '0;
        r_ex_we <= 1'b0;
        r_ex_ld <= 1'b0;
        r_fwd_a <= FWD_RF;
        r_fwd_b <= FWD_RF;
      end else begin
        r_ex_rd <= i_id_rd;
        r_ex_we <= i_id_rd_we & i_id_valid;
        r_ex_ld <= i_id_mem_re;
        r_fwd_a <= w_fwd_a;
        r_fwd_b <= w_fwd_b;
      end
      // A flush drops the pending stall, so it is not counted.
      if (w_raw_stall && !i_flush && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign o_fwd_a     = r_fwd_a;
  assign o_fwd_b     = r_fwd_b;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench: u0 forwards (FWD_EN=1, 32-bit counter), u1 interlocks only (FWD_EN=0, 4-bit counter).
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_re;
  logic       id_rs2_re;
  logic [4:0] id_rd;
  logic       id_rd_we;
  logic       id_mem_re;
  logic       flush;
  logic       mem_stall;

  logic        s0_if, s0_id, b0_ex;
  logic [1:0]  f0_a, f0_b;
  logic [31:0] c0;
  logic        s1_if, s1_id, b1_ex;
  logic [1:0]  f1_a, f1_b;
  logic [3:0]  c1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_unit #(.REG_ADDR_W(5), .FWD_EN(1'b1), .CNT_W(32)) u0 (
    .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rs1_re(id_rs1_re), .i_id_rs2_re(id_rs2_re),
    .i_id_rd(id_rd), .i_id_rd_we(id_rd_we), .i_id_mem_re(id_mem_re),
    .i_flush(flush), .i_mem_stall(mem_stall),
    .o_stall_if(s0_if), .o_stall_id(s0_id), .o_bubble_ex(b0_ex),
    .o_fwd_a(f0_a), .o_fwd_b(f0_b), .o_stall_cnt(c0)
  );

  hazard_unit #(.REG_ADDR_W(5), .FWD_EN(1'b0), .CNT_W(4)) u1 (
    .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rs1_re(id_rs1_re), .i_id_rs2_re(id_rs2_re),
    .i_id_rd(id_rd), .i_id_rd_we(id_rd_we), .i_id_mem_re(id_mem_re),
    .i_flush(flush), .i_mem_stall(mem_stall),
    .o_stall_if(s1_if), .o_stall_id(s1_id), .o_bubble_ex(b1_ex),
    .o_fwd_a(f1_a), .o_fwd_b(f1_b), .o_stall_cnt(c1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic re1,
                        input logic [4:0] rs2, input logic re2,
                        input logic [4:0] rd, input logic we, input logic ld);
    id_valid = v; id_rs1 = rs1; id_rs1_re = re1; id_rs2 = rs2; id_rs2_re = re2;
    id_rd = rd; id_rd_we = we; id_mem_re = ld;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; mem_stall = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_stall_if", s0_if, 0);
    chk("rst_stall_id", s0_id, 0);
    chk("rst_bubble", b0_ex, 0);
    chk("rst_fwd_a", f0_a, 0);
    chk("rst_fwd_b", f0_b, 0);
    chk("rst_cnt", c0, 0);

    // 1: addi x5 then add x6,x5,x1 -> forward from EX/MEM, no stall
    set_id(1, 1, 1, 0, 0, 5, 1, 0);
    tick();
    set_id(1, 5, 1, 1, 1, 6, 1, 0);
    chk("t1_no_stall", s0_if, 0);
    chk("t1_no_bubble", b0_ex, 0);
    tick();
    chk("t1_fwd_a", f0_a, 2'b01);
    chk("t1_fwd_b", f0_b, 2'b00);

    // 2: lw x5 then add x6,x5,x5 -> one load-use stall, then forward from MEM/WB
    set_id(1, 2, 1, 0, 0, 5, 1, 1);
    tick();
    set_id(1, 5, 1, 5, 1, 6, 1, 0);
    chk("t2_stall_if", s0_if, 1);
    chk("t2_stall_id", s0_id, 1);
    chk("t2_bubble", b0_ex, 1);
    tick();
    chk("t2_fwd_bubble", f0_a, 2'b00);
    chk("t2_released", s0_if, 0);
    chk("t2_cnt", c0, 1);
    tick();
    chk("t2_fwd_a", f0_a, 2'b10);
    chk("t2_fwd_b", f0_b, 2'b10);

    // 3: x0 never hazards; an unread rs1 never hazards
    set_id(1, 2, 1, 0, 0, 0, 1, 1);
    tick();
    set_id(1, 0, 1, 0, 1, 6, 1, 0);
    chk("t3_x0_no_stall", s0_if, 0);
    tick();
    chk("t3_x0_fwd_a", f0_a, 2'b00);
    set_id(1, 2, 1, 0, 0, 5, 1, 1);
    tick();
    set_id(1, 5, 0, 0, 1, 6, 1, 0);
    chk("t3_re0_no_stall", s0_if, 0);
    tick();
    chk("t3_re0_fwd_a", f0_a, 2'b00);

    // 4: load-use under a 3-cycle memory stall
    set_id(1, 2, 1, 0, 0, 5, 1, 1);
    tick();
    set_id(1, 5, 1, 5, 1, 6, 1, 0);
    mem_stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t4_ms_stall_if", s0_if, 1);
      chk("t4_ms_bubble", b0_ex, 0);
      tick();
    end
    chk("t4_ms_cnt_frozen", c0, 1);
    mem_stall = 1'b0;
    #1;
    chk("t4_resume_stall", s0_if, 1);
    chk("t4_resume_bubble", b0_ex, 1);
    tick();
    chk("t4_cnt", c0, 2);
    chk("t4_released", s0_if, 0);
    tick();
    chk("t4_fwd_a", f0_a, 2'b10);

    // 5: flush beats load-use; then reset mid-sequence
    set_id(1, 2, 1, 0, 0, 5, 1, 1);
    tick();
    set_id(1, 5, 1, 5, 1, 6, 1, 0);
    flush = 1'b1;
    #1;
    chk("t5_flush_stall_if", s0_if, 0);
    chk("t5_flush_bubble", b0_ex, 1);
    tick();
    flush = 1'b0;
    chk("t5_cnt", c0, 2);
    set_id(1, 1, 1, 0, 0, 7, 1, 0);
    tick();
    set_id(1, 7, 1, 7, 1, 8, 1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_rst_fwd_a", f0_a, 0);
    chk("t5_rst_fwd_b", f0_b, 0);
    chk("t5_rst_cnt", c0, 0);
    chk("t5_rst_stall", s0_if, 0);

    // 6: interlock-only instance: two stall cycles, issue on the third
    set_id(1, 0, 1, 0, 0, 5, 1, 0);
    tick();
    set_id(1, 5, 1, 0, 1, 6, 1, 0);
    chk("t6_stall_ex", s1_if, 1);
    chk("t6_bubble_ex", b1_ex, 1);
    tick();
    chk("t6_stall_mem", s1_id, 1);
    tick();
    chk("t6_issue", s1_if, 0);
    tick();
    chk("t6_fwd_a", f1_a, 2'b00);
    chk("t6_cnt", c1, 2);

    // 6 more rounds of two stalls each -> 14, one more -> 15, another holds at 15
    for (int r = 0; r < 8; r++) begin
      set_id(1, 0, 1, 0, 0, 5, 1, 0);
      tick();
      set_id(1, 5, 1, 0, 1, 6, 1, 0);
      tick(); tick(); tick();
      if (r == 5) chk("t6_cnt_14", c1, 14);
      if (r == 6) chk("t6_cnt_sat", c1, 15);
      if (r == 7) chk("t6_cnt_hold", c1, 15);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
